// File: rtl/seq_mult_4x3.sv
// Sequential shift-and-add multiplier: WA-bit multiplicand x WB-bit multiplier,
// one add-shift per multiplier bit, start/busy/done handshake.

module seq_mult_4x3_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module seq_mult_4x3 #(
    parameter int WA = 4,
    parameter int WB = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic             busy,
    output logic             done,
    output logic [WA+WB-1:0] product
);
    localparam int CW = $clog2(WB + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WA-1:0]      r_mcand;
    logic [WA:0]        r_hi;
    logic [WB-1:0]      r_lo;
    logic [CW-1:0]      r_cnt;
    logic [WA+WB-1:0]   r_product;

    logic [WA-1:0]      w_addend;
    logic [WA-1:0]      w_sum;
    logic [WA:0]        w_carry;
    logic [WA+WB:0]     w_shift;
    logic               w_last;
    logic               w_unused_bits;

    // Gating the addend to zero makes the chain pass hi through with carry 0
    assign w_addend   = r_lo[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WA; i++) begin : g_fa
        seq_mult_4x3_fa u_fa (
            .i_a    (r_hi[i]),
            .i_b    (w_addend[i]),
            .i_cin  (w_carry[i]),
            .o_s    (w_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    // {hi,lo} after this iteration's add, shifted right by one
    assign w_shift = {1'b0, w_carry[WA], w_sum, r_lo[WB-1:1]};
    assign w_last  = (r_cnt == CW'(WB - 1));

    // The top accumulator bit is always zero once shifted; kept only for width
    assign w_unused_bits = r_hi[WA] ^ w_shift[WA+WB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_lo    <= b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_hi  <= w_shift[WA+WB:WB];
                    r_lo  <= w_shift[WB-1:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_shift[WA+WB-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: doc/seq_mult_4x3.md
Name: seq_mult_4x3

Overview:
- Sequential shift-and-add multiplier: unsigned 4-bit multiplicand × 3-bit multiplier → 7-bit product.
- Accumulate path is a WA-bit ripple chain of the team's existing one-bit full adder cells, carry-in tied 0, final carry kept.
- Handshake-controlled datapath block with a start/busy/done interface to the surrounding control logic.
- Trades area for latency: one add-shift per multiplier bit instead of a full combinational array.

Parameters:
- WA, 4, multiplicand width (adder chain length).
- WB, 3, multiplier width (iteration count).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WA  multiplicand; captured on accepted start.
- b  input  WB  multiplier; captured on accepted start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; product valid.
- product  output  WA+WB  result register; held until next result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - rst_n low: state=IDLE; busy=0, done=0, product=0; all internal registers (mcand, hi, lo, cnt) = 0.
  - Reset mid-operation aborts immediately. No partial result reaches product.
- Internal registers:
  - mcand[WA-1:0]
  - hi[WA:0] (accumulator incl. carry bit)
  - lo[WB-1:0] (multiplier, shifted out LSB-first)
  - cnt, ceil(log2(WB+1)) bits
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at a rising edge: mcand<=a, lo<=b, hi<=0, cnt<=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC, one iteration per cycle:
  - If lo[0]=1: s = hi[WA-1:0] + mcand through the full adder chain, cin=0, giving WA sum bits and carry c. Otherwise s = hi[WA-1:0], c = 0.
  - Shift right: hi <= {1'b0, c, s[WA-1:1]}, lo <= {s[0], lo[WB-1:1]}. {hi,lo} is shifted as one (WA+1+WB)-bit word.
  - cnt <= cnt+1.
  - When cnt==WB-1 at the edge: go to DONE, and load product <= {hi,lo}[WA+WB-1:0] computed from this final iteration.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Outputs are registered/decoded from state: busy=1 in CALC and DONE; done=1 only in DONE.
- Latency: start accepted at edge k → CALC on edges k+1..k+WB → done high during the cycle after edge k+WB, with product valid from that edge.
  - Defaults: 3 CALC cycles; done appears the 4th cycle after start is sampled.
- Throughput: start may be asserted during DONE but is ignored. The earliest accepted start is the first IDLE cycle, giving 5 cycles per product with defaults.
- start while busy is ignored. a/b changes while busy have no effect, since operands are captured only at acceptance.
- product holds its last value through IDLE and CALC. It changes only at entry to DONE, and is cleared only by reset.
- Width rule: max result (2^WA-1)(2^WB-1) = 105 fits in WA+WB bits, so there is no overflow. The carry bit hi[WA] is always 0 after each shift.
- start held high continuously: a new operation begins every 5 cycles with defaults.

Test Plan:
- Reset low, then release; a=15, b=7, pulse start → busy high for 4 cycles, done pulse on the 4th, product=105 (7'h69), held afterwards.
- Corners: a=0,b=5 → product=0; a=9,b=0 → product=0; a=5,b=3 → product=15; a=15,b=1 → product=15; a=1,b=7 → product=7. Sweep all 128 operand pairs against the a*b reference model.
- After start with a=6,b=5: re-assert start with a=15,b=7 during CALC and during DONE; change a/b → both ignored, product=30, single done pulse.
- Start a=15,b=7, assert rst_n low mid-CALC (2nd iteration) → immediately busy=0, done=0, product=0. Release and run a=3,b=3 → product=9.
- Hold start=1 with a=2,b=3 then a=4,b=6 changing on IDLE cycles → product=6 then product=24, done pulses 5 cycles apart, no lost or duplicated results.
- Check busy/done timing exactly: done never high outside DONE, done never two consecutive cycles, product stable every cycle except the DONE-entry edge.
